// File: rtl/cu_pkg.sv
// Shared definitions for the control sequencer: opcodes, FSM states, IR field
// positions and ALU select bit positions (datapath ALU port order).
package cu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    localparam int ALU_W     = 13;
    localparam int ALU_AND   = 12;
    localparam int ALU_OR    = 11;
    localparam int ALU_ADD   = 10;
    localparam int ALU_SUB   = 9;
    localparam int ALU_MUL   = 8;
    localparam int ALU_DIV   = 7;
    localparam int ALU_SHR   = 6;
    localparam int ALU_SHL   = 5;
    localparam int ALU_ROR   = 4;
    localparam int ALU_ROL   = 3;
    localparam int ALU_NEG   = 2;
    localparam int ALU_NOT   = 1;
    localparam int ALU_INCPC = 0;

    // Wide enough for MULDIV_CYCLES-1 up to 31.
    localparam int CNT_W = 5;

    typedef enum logic [3:0] {
        ST_F0, ST_F1, ST_F2, ST_DEC, ST_EX1, ST_EX2, ST_EX3, ST_EX4, ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU2, CLS_MULDIV, CLS_UNARY, CLS_NOP, CLS_HALT, CLS_ILLEGAL
    } op_class_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        op_class_t c;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: c = CLS_ALU2;
            OP_MUL, OP_DIV:                 c = CLS_MULDIV;
            OP_NEG, OP_NOT:                 c = CLS_UNARY;
            OP_NOP:                         c = CLS_NOP;
            OP_HALT:                        c = CLS_HALT;
            default:                        c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic logic [ALU_W-1:0] alu_sel(input logic [4:0] op);
        logic [ALU_W-1:0] s;
        s = '0;
        case (op)
            OP_AND: s[ALU_AND] = 1'b1;
            OP_OR:  s[ALU_OR]  = 1'b1;
            OP_ADD: s[ALU_ADD] = 1'b1;
            OP_SUB: s[ALU_SUB] = 1'b1;
            OP_MUL: s[ALU_MUL] = 1'b1;
            OP_DIV: s[ALU_DIV] = 1'b1;
            OP_SHR: s[ALU_SHR] = 1'b1;
            OP_SHL: s[ALU_SHL] = 1'b1;
            OP_ROR: s[ALU_ROR] = 1'b1;
            OP_ROL: s[ALU_ROL] = 1'b1;
            OP_NEG: s[ALU_NEG] = 1'b1;
            OP_NOT: s[ALU_NOT] = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/reg_sel_decode.sv
// 4-bit register index plus enable to a 16-bit one-hot select.
module reg_sel_decode (
    input  logic [3:0]  idx_i,
    input  logic        en_i,
    output logic [15:0] onehot_o
);

    assign onehot_o = en_i ? (16'h0001 << idx_i) : 16'h0000;

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer for the 32-bit bus datapath.
// Build option: define CU_ILLEGAL_TRAP_EN to halt on an unsupported opcode.
module control_unit
    import cu_pkg::*;
#(
    parameter int MULDIV_CYCLES = 1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [31:0]       ir,
    input  logic              mem_rdy,
    output logic [15:0]       reg_in,
    output logic [15:0]       reg_out,
    output logic              pc_out,
    output logic              pc_in,
    output logic              mar_in,
    output logic              ir_in,
    output logic              y_in,
    output logic              z_in,
    output logic              hi_in,
    output logic              lo_in,
    output logic              zhigh_out,
    output logic              zlow_out,
    output logic              mdr_out,
    output logic              mdr_in,
    output logic              read,
    output logic [ALU_W-1:0]  alu_op,
    output logic              halted,
    output logic              illegal
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             illegal_q;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    op_class_t  cls;
    logic       unused_ir_bits;

    assign opcode         = ir[OPC_HI:OPC_LO];
    assign ra             = ir[RA_HI:RA_LO];
    assign rb             = ir[RB_HI:RB_LO];
    assign rc             = ir[RC_HI:RC_LO];
    assign cls            = op_class(opcode);
    assign unused_ir_bits = ^ir[RC_LO-1:0];

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= ST_F0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                ST_F0:   state_q <= ST_F1;
                ST_F1:   if (mem_rdy) state_q <= ST_F2;
                ST_F2:   state_q <= ST_DEC;
                ST_DEC: begin
                    case (cls)
                        CLS_ALU2, CLS_MULDIV: state_q <= ST_EX1;
                        CLS_UNARY:            state_q <= ST_EX2;
                        CLS_HALT:             state_q <= ST_HALT;
                        CLS_ILLEGAL: begin
                            illegal_q <= 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
                            state_q   <= ST_HALT;
`else
                            state_q   <= ST_F0;
`endif
                        end
                        default:              state_q <= ST_F0;
                    endcase
                end
                ST_EX1: begin
                    state_q <= ST_EX2;
                    if (cls == CLS_MULDIV) cnt_q <= CNT_LOAD;
                end
                // MUL/DIV dwell here until the counter reaches zero.
                ST_EX2: begin
                    if (cls == CLS_MULDIV && cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= ST_EX3;
                    end
                end
                ST_EX3:  state_q <= (cls == CLS_MULDIV) ? ST_EX4 : ST_F0;
                ST_EX4:  state_q <= ST_F0;
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_F0;
            endcase
        end
    end

    logic       rout_en, rin_en;
    logic [3:0] rout_idx, rin_idx;

    always_comb begin
        rout_en   = 1'b0;
        rout_idx  = 4'd0;
        rin_en    = 1'b0;
        rin_idx   = 4'd0;
        pc_out    = 1'b0;
        pc_in     = 1'b0;
        mar_in    = 1'b0;
        ir_in     = 1'b0;
        y_in      = 1'b0;
        z_in      = 1'b0;
        hi_in     = 1'b0;
        lo_in     = 1'b0;
        zhigh_out = 1'b0;
        zlow_out  = 1'b0;
        mdr_out   = 1'b0;
        mdr_in    = 1'b0;
        read      = 1'b0;
        alu_op    = '0;
        if (!clear) begin
            case (state_q)
                ST_F0: begin
                    pc_out            = 1'b1;
                    mar_in            = 1'b1;
                    alu_op[ALU_INCPC] = 1'b1;
                    z_in              = 1'b1;
                end
                // Incremented PC and MDR are committed only on the exit cycle.
                ST_F1: begin
                    read     = 1'b1;
                    mdr_in   = mem_rdy;
                    pc_in    = mem_rdy;
                    zlow_out = mem_rdy;
                end
                ST_F2: begin
                    mdr_out = 1'b1;
                    ir_in   = 1'b1;
                end
                ST_EX1: begin
                    rout_en  = 1'b1;
                    rout_idx = (cls == CLS_MULDIV) ? ra : rb;
                    y_in     = 1'b1;
                end
                ST_EX2: begin
                    rout_en  = 1'b1;
                    rout_idx = (cls == CLS_ALU2) ? rc : rb;
                    alu_op   = alu_sel(opcode);
                    z_in     = 1'b1;
                end
                ST_EX3: begin
                    zlow_out = 1'b1;
                    if (cls == CLS_MULDIV) begin
                        lo_in = 1'b1;
                    end else begin
                        rin_en  = 1'b1;
                        rin_idx = ra;
                    end
                end
                ST_EX4: begin
                    zhigh_out = 1'b1;
                    hi_in     = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign halted  = (state_q == ST_HALT);
    assign illegal = illegal_q;

    reg_sel_decode u_rin_dec (
        .idx_i    (rin_idx),
        .en_i     (rin_en),
        .onehot_o (reg_in)
    );

    reg_sel_decode u_rout_dec (
        .idx_i    (rout_idx),
        .en_i     (rout_en),
        .onehot_o (reg_out)
    );

endmodule

// File: tb/tb_control_unit.sv
// Directed and randomized bench for control_unit; expected strobe traces are
// generated per instruction from the opcode rules and compared cycle by cycle.
module tb_control_unit;

    localparam int MD = 4;

    logic        clk = 1'b0;
    logic        clear;
    logic [31:0] ir;
    logic        mem_rdy;
    logic [15:0] reg_in, reg_out;
    logic        pc_out, pc_in, mar_in, ir_in, y_in, z_in, hi_in, lo_in;
    logic        zhigh_out, zlow_out, mdr_out, mdr_in, read;
    logic [12:0] alu_op;
    logic        halted, illegal;

    always #5 clk = ~clk;

    control_unit #(.MULDIV_CYCLES(MD)) dut (
        .clk(clk), .clear(clear), .ir(ir), .mem_rdy(mem_rdy),
        .reg_in(reg_in), .reg_out(reg_out),
        .pc_out(pc_out), .pc_in(pc_in), .mar_in(mar_in), .ir_in(ir_in),
        .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in),
        .zhigh_out(zhigh_out), .zlow_out(zlow_out), .mdr_out(mdr_out),
        .mdr_in(mdr_in), .read(read), .alu_op(alu_op),
        .halted(halted), .illegal(illegal)
    );

    typedef struct packed {
        logic [15:0] reg_in;
        logic [15:0] reg_out;
        logic [12:0] alu;
        logic pc_out, pc_in, mar_in, ir_in, y_in, z_in, hi_in, lo_in;
        logic zhigh_out, zlow_out, mdr_out, mdr_in, read, halted, illegal;
    } sv_t;

    typedef struct {
        bit  mr;
        bit  ld;
        sv_t e;
    } cyc_t;

    cyc_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          ill_m = 1'b0;
    logic [31:0] ir_next;

    // ALU one-hot order, MSB first: AND OR ADD SUB MUL DIV SHR SHL ROR ROL NEG NOT IncPC
    function automatic sv_t obs();
        sv_t a;
        a.reg_in = reg_in;   a.reg_out = reg_out;  a.alu = alu_op;
        a.pc_out = pc_out;   a.pc_in = pc_in;      a.mar_in = mar_in;
        a.ir_in = ir_in;     a.y_in = y_in;        a.z_in = z_in;
        a.hi_in = hi_in;     a.lo_in = lo_in;      a.zhigh_out = zhigh_out;
        a.zlow_out = zlow_out; a.mdr_out = mdr_out; a.mdr_in = mdr_in;
        a.read = read;       a.halted = halted;    a.illegal = illegal;
        return a;
    endfunction

    function automatic sv_t base();
        sv_t e;
        e = '0;
        e.illegal = ill_m;
        return e;
    endfunction

    function automatic void push(bit mr, bit ld, sv_t e);
        cyc_t c;
        c.mr = mr;
        c.ld = ld;
        c.e  = e;
        q.push_back(c);
    endfunction

    task automatic chk(input string tag, input sv_t exp);
        sv_t a;
        a = obs();
        n_cmp++;
        assert (a === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, a, exp);
        end
    endtask

    // kind: 1 two-operand ALU, 2 mul/div, 3 neg/not, 4 nop, 5 halt, 0 unsupported
    task automatic build(input logic [31:0] irv, input int waits);
        sv_t e;
        int  kind, abit;
        logic [3:0] ra, rb, rc;
        ra = irv[26:23]; rb = irv[22:19]; rc = irv[18:15];
        kind = 0; abit = 0;
        case (irv[31:27])
            5'b00101: begin kind = 1; abit = 12; end
            5'b00110: begin kind = 1; abit = 11; end
            5'b00011: begin kind = 1; abit = 10; end
            5'b00100: begin kind = 1; abit = 9;  end
            5'b01110: begin kind = 2; abit = 8;  end
            5'b01111: begin kind = 2; abit = 7;  end
            5'b00111: begin kind = 1; abit = 6;  end
            5'b01000: begin kind = 1; abit = 5;  end
            5'b01001: begin kind = 1; abit = 4;  end
            5'b01010: begin kind = 1; abit = 3;  end
            5'b10000: begin kind = 3; abit = 2;  end
            5'b10001: begin kind = 3; abit = 1;  end
            5'b11010: kind = 4;
            5'b11011: kind = 5;
            default:  kind = 0;
        endcase
        q.delete();
        ir_next = irv;
        e = base(); e.pc_out = 1; e.mar_in = 1; e.alu[0] = 1; e.z_in = 1;
        push(1'($urandom_range(0, 1)), 1'b0, e);
        for (int w = 0; w < waits; w++) begin
            e = base(); e.read = 1;
            push(1'b0, 1'b0, e);
        end
        e = base(); e.read = 1; e.mdr_in = 1; e.pc_in = 1; e.zlow_out = 1;
        push(1'b1, 1'b0, e);
        e = base(); e.mdr_out = 1; e.ir_in = 1;
        push(1'($urandom_range(0, 1)), 1'b0, e);
        push(1'($urandom_range(0, 1)), 1'b1, base());
        if (kind == 0) ill_m = 1'b1;
        if (kind == 1 || kind == 2) begin
            e = base(); e.reg_out = 16'h0001 << ((kind == 2) ? ra : rb); e.y_in = 1;
            push(1'($urandom_range(0, 1)), 1'b0, e);
        end
        if (kind >= 1 && kind <= 3) begin
            for (int c = 0; c < ((kind == 2) ? MD : 1); c++) begin
                e = base(); e.reg_out = 16'h0001 << ((kind == 1) ? rc : rb);
                e.alu = 13'h0001 << abit; e.z_in = 1;
                push(1'($urandom_range(0, 1)), 1'b0, e);
            end
            e = base(); e.zlow_out = 1;
            if (kind == 2) e.lo_in = 1; else e.reg_in = 16'h0001 << ra;
            push(1'($urandom_range(0, 1)), 1'b0, e);
        end
        if (kind == 2) begin
            e = base(); e.zhigh_out = 1; e.hi_in = 1;
            push(1'($urandom_range(0, 1)), 1'b0, e);
        end
    endtask

    task automatic play(input string tag, input int n);
        for (int i = 0; i < n && i < q.size(); i++) begin
            @(negedge clk);
            clear   = 1'b0;
            mem_rdy = q[i].mr;
            if (q[i].ld) ir = ir_next;
            #1 chk($sformatf("%s[%0d]", tag, i), q[i].e);
        end
    endtask

    task automatic halt_check(input string tag, input int n);
        sv_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_rdy = 1'($urandom_range(0, 1));
            e = base(); e.halted = 1;
            #1 chk($sformatf("%s[%0d]", tag, i), e);
        end
    endtask

    task automatic do_clear(input string tag, input bit halted_now);
        sv_t e;
        @(negedge clk);
        clear   = 1'b1;
        mem_rdy = 1'($urandom_range(0, 1));
        e = base(); e.halted = halted_now;
        #1 chk({tag, "_clr0"}, e);
        ill_m = 1'b0;
        @(negedge clk);
        mem_rdy = 1'($urandom_range(0, 1));
        #1 chk({tag, "_clr1"}, base());
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op);
        return {op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 15'($urandom)};
    endfunction

    logic [4:0] ops [13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                             5'b01000, 5'b01001, 5'b01010, 5'b01110, 5'b01111,
                             5'b10000, 5'b10001, 5'b11010};

    initial begin
        clear = 1'b1; ir = 32'h0; mem_rdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1 chk("reset", base());

        build(32'h18918000, 0);
        play("add_r1_r2_r3", q.size());

        build(mk(5'b00110), 3);
        play("fetch_wait3", q.size());

        build({5'b01110, 4'd4, 4'd5, 4'd0, 15'd0}, 0);
        play("mul_r4_r5", q.size());

        for (int k = 0; k < 30; k++) begin
            build(mk(ops[$urandom_range(0, 12)]), $urandom_range(0, 2));
            play($sformatf("rand%0d", k), q.size());
        end

        build(mk(5'b00100), 1);
        play("sub_abort", 6);
        do_clear("sub_abort", 1'b0);
        build(mk(5'b11010), 0);
        play("nop_after_abort", q.size());

        build(mk(5'b11111), 0);
        play("illegal", q.size());
`ifdef CU_ILLEGAL_TRAP_EN
        halt_check("illegal_trap", 5);
        do_clear("illegal_trap", 1'b1);
`else
        build(mk(5'b00011), 0);
        play("after_illegal", q.size());
        do_clear("illegal", 1'b0);
`endif

        build(mk(5'b11011), 1);
        play("halt", q.size());
        halt_check("halted", 20);
        do_clear("halt", 1'b1);
        build(mk(ops[$urandom_range(0, 12)]), 0);
        play("after_halt", q.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
